lcd_reader: RTL

- Read-side companion to the HD44780 16x2 LCD write path. Performs bus read cycles on the LCD interface with LCD_RW=1.
- Supports a single read of the busy flag/address (RS=0) or of DDRAM/CGRAM data (RS=1).
- Supports an auto-poll mode that repeats busy-flag reads until BF=0 or a timeout.
- Sits beside LCD_Controller. The top level muxes LCD_RW/LCD_EN/LCD_RS between the two, selected by oACTIVE.

---
 rtl/lcd_reader.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/lcd_reader.sv
// lcd_reader: read-side bus sequencer for an HD44780 16x2 LCD.
// Runs one or more LCD_RW=1 read cycles (setup, enable pulse, hold) and
// captures LCD_DATA at the end of each enable pulse. In poll mode it keeps
// reading the busy flag, with an idle gap between reads, until BF=0 or the
// read budget runs out. The LCD bus is only ever read, never driven.
module lcd_reader #(
    parameter int unsigned T_SETUP   = 4,
    parameter int unsigned T_EN_HIGH = 16,
    parameter int unsigned T_HOLD    = 4,
    parameter int unsigned T_GAP     = 50,
    parameter int unsigned MAX_POLLS = 4096
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic       iStart,
    input  logic       iRS,
    input  logic       iPOLL,
    output logic [7:0] oDATA,
    output logic       oBUSY_FLAG,
    output logic [6:0] oADDR,
    output logic       oDone,
    output logic       oTIMEOUT,
    output logic       oACTIVE,
    inout  wire  [7:0] LCD_DATA,
    output logic       LCD_RW,
    output logic       LCD_EN,
    output logic       LCD_RS
);

    localparam int unsigned T_MAX_A = (T_SETUP > T_EN_HIGH) ? T_SETUP : T_EN_HIGH;
    localparam int unsigned T_MAX_B = (T_HOLD > T_GAP) ? T_HOLD : T_GAP;
    localparam int unsigned T_MAX   = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
    localparam int unsigned CNT_W   = (T_MAX > 1) ? $clog2(T_MAX) : 1;
    localparam int unsigned POLL_W  = $clog2(MAX_POLLS + 1);

    localparam logic [CNT_W-1:0]  LD_SETUP = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0]  LD_EN    = CNT_W'(T_EN_HIGH - 1);
    localparam logic [CNT_W-1:0]  LD_HOLD  = CNT_W'(T_HOLD - 1);
    localparam logic [CNT_W-1:0]  LD_GAP   = CNT_W'(T_GAP - 1);
    localparam logic [POLL_W-1:0] POLL_MAX = POLL_W'(MAX_POLLS);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_EN_HI = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic [POLL_W-1:0] poll_cnt;
    logic              start_d;
    logic              rs_lat;
    logic              poll_lat;
    logic              timeout_r;
    logic [7:0]        data_r;
    logic              bf_r;
    logic [6:0]        addr_r;
    logic              start_edge;
    logic              bus_phase;

    // This block only listens on the LCD bus.
    assign LCD_DATA = 8'hzz;

    assign start_edge = iStart & ~start_d & (state == S_IDLE);

    // Bus strobes and status flags decode from registered state only, so no
    // path exists from LCD_DATA to any output.
    assign bus_phase  = (state == S_SETUP) || (state == S_EN_HI) || (state == S_HOLD);
    assign LCD_RW     = bus_phase;
    assign LCD_EN     = (state == S_EN_HI);
    assign LCD_RS     = bus_phase & rs_lat;
    assign oDone      = (state == S_DONE);
    assign oACTIVE    = (state != S_IDLE);
    assign oTIMEOUT   = timeout_r;
    assign oDATA      = data_r;
    assign oBUSY_FLAG = bf_r;
    assign oADDR      = addr_r;

    // Read-cycle sequencer: one down-counter reloaded on every state entry.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state     <= S_IDLE;
            cnt       <= '0;
            poll_cnt  <= '0;
            start_d   <= 1'b0;
            rs_lat    <= 1'b0;
            poll_lat  <= 1'b0;
            timeout_r <= 1'b0;
            data_r    <= '0;
            bf_r      <= 1'b0;
            addr_r    <= '0;
        end else begin
            start_d <= iStart;
            case (state)
                S_IDLE: begin
                    if (start_edge) begin
                        state     <= S_SETUP;
                        cnt       <= LD_SETUP;
                        rs_lat    <= ~iPOLL & iRS;
                        poll_lat  <= iPOLL;
                        timeout_r <= 1'b0;
                        poll_cnt  <= '0;
                    end
                end
                S_SETUP: begin
                    if (cnt == '0) begin
                        state <= S_EN_HI;
                        cnt   <= LD_EN;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_EN_HI: begin
                    if (cnt == '0) begin
                        state  <= S_HOLD;
                        cnt    <= LD_HOLD;
                        data_r <= LCD_DATA;
                        if (!rs_lat) begin
                            bf_r   <= LCD_DATA[7];
                            addr_r <= LCD_DATA[6:0];
                        end
                        if (poll_lat && (poll_cnt != POLL_MAX)) begin
                            poll_cnt <= poll_cnt + 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_HOLD: begin
                    if (cnt == '0) begin
                        if (!poll_lat || !data_r[7]) begin
                            state <= S_DONE;
                        end else if (poll_cnt < POLL_MAX) begin
                            state <= S_GAP;
                            cnt   <= LD_GAP;
                        end else begin
                            state     <= S_DONE;
                            timeout_r <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_GAP: begin
                    if (cnt == '0) begin
                        state <= S_SETUP;
                        cnt   <= LD_SETUP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
